// File: rtl/txn_pkg.sv
// Shared types and constants for the request/response endpoint and its bench-side classes.
package txn_pkg;

  localparam int TXN_ADDR_W    = 4;
  localparam int TXN_DATA_W    = 8;
  localparam int TXN_NUM_REGS  = 12;
  localparam int TXN_RSP_DEPTH = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic                  write;
    logic [TXN_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

  function automatic logic addr_in_range(input logic [TXN_ADDR_W-1:0] addr,
                                         input int unsigned num_regs);
    return 32'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/txn_rsp_fifo.sv
// Synchronous response FIFO; storage is cleared on reset so the head never reads X.
module txn_rsp_fifo
  import txn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  rsp_t                       push_data,
  input  logic                       pop,
  output rsp_t                       pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rsp_t             mem_q [DEPTH];
  rsp_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/txn_responder.sv
// Request/response endpoint: register array, accept logic, response queue and transaction counter.
module txn_responder
  import txn_pkg::*;
#(
  parameter int ADDR_W    = TXN_ADDR_W,
  parameter int DATA_W    = TXN_DATA_W,  // must match TXN_DATA_W, the width carried in rsp_t
  parameter int NUM_REGS  = TXN_NUM_REGS,
  parameter int RSP_DEPTH = TXN_RSP_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_count
);

  localparam int CNT_W = $clog2(RSP_DEPTH+1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [15:0]       txn_count_q, txn_count_d;
  logic [DATA_W-1:0] rd_val;
  logic              accept, in_range, rsp_pop;
  logic              fifo_empty, unused_fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  rsp_t              push_rsp, head_rsp;

  // Ready comes only from the registered fill level, never from rsp_ready.
  assign req_ready = (fifo_count < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = ~fifo_empty;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign txn_count = txn_count_q;

  assign rsp_write = rsp_valid & head_rsp.write;
  assign rsp_rdata = rsp_valid ? head_rsp.rdata : '0;
  assign rsp_err   = rsp_valid & head_rsp.err;

  always_comb begin
    regs_d      = regs_q;
    rd_val      = '0;
    txn_count_d = txn_count_q;
    in_range    = addr_in_range(req_addr, NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        rd_val = regs_q[i];
        if (accept && req_write == OP_WRITE) begin
          regs_d[i] = req_wdata;
        end
      end
    end
    // Read data is the pre-edge register value; writes and errors return zero.
    push_rsp.write = req_write;
    push_rsp.err   = ~in_range;
    push_rsp.rdata = (req_write == OP_READ && in_range) ? rd_val : '0;
    if (accept) begin
      txn_count_d = txn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      txn_count_q <= '0;
    end else begin
      regs_q      <= regs_d;
      txn_count_q <= txn_count_d;
    end
  end

  txn_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_data(push_rsp),
    .pop      (rsp_pop),
    .pop_data (head_rsp),
    .count    (fifo_count),
    .full     (unused_fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_txn_responder.sv
// Bench for txn_responder: queue/array reference model checked every cycle, plus directed literal checks.
module tb_txn_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [15:0] txn_count;

  int passed = 0;
  int total  = 0;

  txn_responder dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: pending responses in order, register contents, accept count.
  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t        m_q[$];
  logic [7:0]  m_regs [16];
  logic [15:0] m_count = '0;
  bit          started = 0;

  always @(posedge clk) begin : model
    exp_t e;
    bit   acc, pop;
    if (reset) begin
      m_q.delete();
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_count = 16'h0000;
      started = 1;
    end else if (started) begin
      acc = req_valid && (m_q.size() < 4);
      pop = rsp_ready && (m_q.size() > 0);
      e.w = req_write;
      e.e = (req_addr >= 4'd12);
      e.d = (!req_write && !e.e) ? m_regs[req_addr] : 8'h00;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(e);
        if (req_write && !e.e) m_regs[req_addr] = req_wdata;
        m_count = m_count + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, m_q.size() < 4});
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_q.size() != 0});
      check("txn_count", {16'b0, txn_count}, {16'b0, m_count});
      if (m_q.size() != 0) begin
        check("rsp_write", {31'b0, rsp_write}, {31'b0, m_q[0].w});
        check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, m_q[0].d});
        check("rsp_err",   {31'b0, rsp_err},   {31'b0, m_q[0].e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [7:0] d);
    bit acc = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      acc = req_ready;
      step();
      if (acc) break;
    end
    req_valid = 1'b0;
    check("send_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid) break;
      step();
    end
    check("drain_empty", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    step();
    step();
    reset = 1'b0;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_txn_count", {16'b0, txn_count}, 32'd0);
    check("rst_rsp_fields", {22'b0, rsp_write, rsp_rdata, rsp_err}, 32'd0);

    // 1: write then read back, one-cycle latency
    rsp_ready = 1'b1;
    send(1'b1, 4'd3, 8'hA5);
    check("t1_wr_valid", {31'b0, rsp_valid}, 32'd1);
    check("t1_wr_rsp", {22'b0, rsp_write, rsp_rdata, rsp_err}, {22'b0, 1'b1, 8'h00, 1'b0});
    send(1'b0, 4'd3, 8'h00);
    check("t1_rd_valid", {31'b0, rsp_valid}, 32'd1);
    check("t1_rd_rsp", {22'b0, rsp_write, rsp_rdata, rsp_err}, {22'b0, 1'b0, 8'hA5, 1'b0});

    // 2: out-of-range accesses, then every register keeps its value
    send(1'b0, 4'd12, 8'h00);
    check("t2_rd_err", {22'b0, rsp_write, rsp_rdata, rsp_err}, {22'b0, 1'b0, 8'h00, 1'b1});
    send(1'b1, 4'd15, 8'h77);
    check("t2_wr_err", {22'b0, rsp_write, rsp_rdata, rsp_err}, {22'b0, 1'b1, 8'h00, 1'b1});
    for (int i = 0; i < 12; i++) begin
      send(1'b0, 4'(i), 8'h00);
      check("t2_readback", {23'b0, rsp_rdata, rsp_err}, {23'b0, (i == 3) ? 8'hA5 : 8'h00, 1'b0});
    end
    drain();

    // 3: back-pressure fills the FIFO at exactly 4
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd5;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) n++;
      step();
    end
    check("t3_accepts", n, 32'd4);
    check("t3_full_ready", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t3_ready_after_pop", {31'b0, req_ready}, 32'd1);
    drain();

    // 4: steady push+pop with two in flight across pointer wrap
    rsp_ready = 1'b0;
    send(1'b0, 4'd3, 8'h00);
    send(1'b1, 4'd7, 8'h3C);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_write = (i % 2) == 0;
      req_addr  = 4'(i + 4);
      req_wdata = 8'(8'h10 + i);
      check("t4_ready", {31'b0, req_ready}, 32'd1);
      step();
    end
    drain();

    // 5: counter wrap
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'd0;
    for (int i = 0; i < 70000; i++) begin
      if (m_count == 16'hFFFE) break;
      step();
    end
    req_valid = 1'b0;
    check("t5_preload", {16'b0, txn_count}, 32'h0000FFFE);
    send(1'b0, 4'd1, 8'h00);
    check("t5_ffff", {16'b0, txn_count}, 32'h0000FFFF);
    send(1'b0, 4'd1, 8'h00);
    check("t5_wrap", {16'b0, txn_count}, 32'h00000000);
    drain();

    // 6: reset with responses pending and a write in the same cycle
    rsp_ready = 1'b0;
    send(1'b0, 4'd2, 8'h00);
    send(1'b0, 4'd4, 8'h00);
    send(1'b0, 4'd6, 8'h00);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 4'd1;
    req_wdata = 8'h5A;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 1'b0;
    check("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_txn_count", {16'b0, txn_count}, 32'd0);
    check("t6_req_ready", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    send(1'b0, 4'd1, 8'h00);
    check("t6_rd_after_rst", {22'b0, rsp_write, rsp_rdata, rsp_err}, 32'd0);
    check("t6_rd_valid", {31'b0, rsp_valid}, 32'd1);

    // random traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req_valid = $urandom_range(0, 2) != 0;
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = 4'($urandom_range(0, 15));
      req_wdata = 8'($urandom);
      rsp_ready = $urandom_range(0, 2) != 0;
      step();
    end
    reset = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
